// File: rtl/fa_share_ctrl.sv
// fa_share_ctrl: round-robin controller that shares one external N-bit full
// adder among NREQ requesters. Requests arrive on a valid/ready handshake.
// Results go out registered and tagged with the owning requester id.
module fa_share_ctrl #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_x,
    input  logic [NREQ*N-1:0] req_y,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      add_X,
    output logic [N-1:0]      add_Y,
    output logic              add_cin,
    input  logic [N-1:0]      add_S,
    input  logic              add_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_sum,
    output logic              res_cout,
    output logic [ID_W-1:0]   res_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] ID_ONE  = ID_W'(1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NREQ - 1);
    localparam logic [ID_W:0]   NREQ_W  = (ID_W + 1)'(NREQ);

    state_t          state_r;
    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] gid_r;
    logic [N-1:0]    op_x_r;
    logic [N-1:0]    op_y_r;
    logic            op_cin_r;
    logic [N-1:0]    sum_r;
    logic            cout_r;
    logic [ID_W-1:0] id_r;
    logic            valid_r;

    logic            grant_found_s;
    logic [ID_W-1:0] grant_id_s;
    logic [NREQ-1:0] ready_s;
    logic [N-1:0]    sel_x_s;
    logic [N-1:0]    sel_y_s;
    logic            sel_cin_s;

    // Round-robin search: first valid requester at or after ptr, wrapping at NREQ.
    always_comb begin
        logic [ID_W:0]   pos_s;
        logic [ID_W-1:0] idx_s;
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        pos_s         = '0;
        idx_s         = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos_s = {1'b0, ptr_r} + (ID_W + 1)'(k);
            if (pos_s >= NREQ_W) begin
                pos_s = pos_s - NREQ_W;
            end else begin
                pos_s = pos_s;
            end
            idx_s = pos_s[ID_W-1:0];
            if (!grant_found_s && req_valid[idx_s]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant, only offered while idle; operands of the winner muxed out.
    always_comb begin
        ready_s   = '0;
        sel_x_s   = req_x[grant_id_s*N +: N];
        sel_y_s   = req_y[grant_id_s*N +: N];
        sel_cin_s = req_cin[grant_id_s];
        if (state_r == IDLE && grant_found_s) begin
            ready_s[grant_id_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign req_ready = ready_s;
    assign add_X     = op_x_r;
    assign add_Y     = op_y_r;
    assign add_cin   = op_cin_r;
    assign res_valid = valid_r;
    assign res_sum   = sum_r;
    assign res_cout  = cout_r;
    assign res_id    = id_r;

    // Transaction FSM: latch winner, drive adder for one cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            gid_r    <= '0;
            op_x_r   <= '0;
            op_y_r   <= '0;
            op_cin_r <= 1'b0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            id_r     <= '0;
            valid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        op_x_r   <= sel_x_s;
                        op_y_r   <= sel_y_s;
                        op_cin_r <= sel_cin_s;
                        gid_r    <= grant_id_s;
                        state_r  <= EXEC;
                    end
                end
                EXEC: begin
                    // Adder inputs are only non-zero during this single cycle.
                    sum_r    <= add_S;
                    cout_r   <= add_cout;
                    id_r     <= gid_r;
                    valid_r  <= 1'b1;
                    op_x_r   <= '0;
                    op_y_r   <= '0;
                    op_cin_r <= 1'b0;
                    state_r  <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        valid_r <= 1'b0;
                        ptr_r   <= (gid_r == ID_LAST) ? '0 : gid_r + ID_ONE;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    valid_r  <= 1'b0;
                    op_x_r   <= '0;
                    op_y_r   <= '0;
                    op_cin_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_share_ctrl.sv
// Bench for fa_share_ctrl: a behavioural adder closes the loop; a round-robin
// reference model predicts grants and pushes expected results into a
// scoreboard that a separate monitor pops when results are handed over.
module tb_fa_share_ctrl;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_x;
    logic [NREQ*N-1:0] req_y;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      add_X;
    logic [N-1:0]      add_Y;
    logic              add_cin;
    logic [N-1:0]      add_S;
    logic              add_cout;
    logic              res_valid;
    logic              res_ready;
    logic [N-1:0]      res_sum;
    logic              res_cout;
    logic [ID_W-1:0]   res_id;

    fa_share_ctrl #(.N(N), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
        .req_ready(req_ready),
        .add_X(add_X), .add_Y(add_Y), .add_cin(add_cin),
        .add_S(add_S), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
    );

    // The shared external adder.
    assign {add_cout, add_S} = {1'b0, add_X} + {1'b0, add_Y} + {{N{1'b0}}, add_cin};

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int sum;
        int cout;
        int t;
    } exp_t;

    exp_t sb[$];
    int   id_log[$];
    int   cyc_log[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model state
    bit   outstanding;
    int   ptr;
    int   gid;
    bit   exec_now, exec_next;
    int   ex_x, ex_y, ex_c, nx_x, nx_y, nx_c;
    bit   head_seen;
    int   last_sum, last_cout;
    exp_t head;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int rr_pick(int p, logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (((v >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    task automatic set_req(int i, int x, int y, int c);
        req_x[i*N +: N] = N'(x);
        req_y[i*N +: N] = N'(y);
        req_cin[i]      = c[0];
    endtask

    // One clock: check grant and adder drive at negedge, update model, return at posedge+1.
    task automatic step();
        int  g;
        bit  rst_edge;
        @(negedge clk);
        if (!rst) begin
            g = outstanding ? -1 : rr_pick(ptr, req_valid);
            check("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
            check("add_X", int'(add_X), exec_now ? ex_x : 0);
            check("add_Y", int'(add_Y), exec_now ? ex_y : 0);
            check("add_cin", int'(add_cin), exec_now ? ex_c : 0);
            if (g >= 0) begin
                exp_t e;
                nx_x = int'(req_x[g*N +: N]);
                nx_y = int'(req_y[g*N +: N]);
                nx_c = int'(req_cin[g]);
                e.id   = g;
                e.sum  = (nx_x + nx_y + nx_c) % 256;
                e.cout = (nx_x + nx_y + nx_c) / 256;
                e.t    = cyc + 2;
                sb.push_back(e);
                outstanding = 1'b1;
                gid = g;
                exec_next = 1'b1;
            end
            if (res_valid && res_ready && outstanding) begin
                outstanding = 1'b0;
                ptr = (gid + 1) % NREQ;
            end
        end
        rst_edge = rst;
        @(posedge clk);
        exec_now = exec_next;
        exec_next = 1'b0;
        ex_x = nx_x; ex_y = nx_y; ex_c = nx_c;
        if (rst_edge) begin
            outstanding = 1'b0;
            ptr = 0;
            exec_now = 1'b0;
            sb.delete();
            head_seen = 1'b0;
        end
        #1;
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                check("res_unexpected", 1, 0);
            end else begin
                head = sb[0];
                check("res_id", int'(res_id), head.id);
                check("res_sum", int'(res_sum), head.sum);
                check("res_cout", int'(res_cout), head.cout);
                if (!head_seen) begin
                    check("res_latency", cyc, head.t);
                    head_seen = 1'b1;
                end
                if (res_ready) begin
                    void'(sb.pop_front());
                    id_log.push_back(int'(res_id));
                    cyc_log.push_back(cyc);
                    last_sum = int'(res_sum);
                    last_cout = int'(res_cout);
                    head_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_cin = '0; res_ready = 1'b0;
        outstanding = 1'b0; ptr = 0; gid = 0; exec_now = 1'b0; exec_next = 1'b0;
        head_seen = 1'b0; nx_x = 0; nx_y = 0; nx_c = 0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_res_sum", int'(res_sum), 0);
        check("reset_res_id", int'(res_id), 0);
        step();

        // Single op with carry out.
        set_req(0, 8'hFF, 8'h01, 0); req_valid = 4'b0001; res_ready = 1'b1;
        step(); req_valid = '0;
        repeat (4) step();
        check("t1_sum", last_sum, 8'h00);
        check("t1_cout", last_cout, 1);

        // Carry-in only.
        set_req(2, 8'h7F, 8'h00, 1); req_valid = 4'b0100;
        step(); req_valid = '0;
        repeat (4) step();
        check("t2_sum", last_sum, 8'h80);
        check("t2_cout", last_cout, 0);

        // Round-robin from reset with everyone requesting.
        for (int i = 0; i < NREQ; i++) set_req(i, 16 * i + 3, 40 + i, i % 2);
        req_valid = 4'b1111; rst = 1'b1;
        step(); rst = 1'b0;
        id_log.delete(); cyc_log.delete();
        repeat (16) step();
        check("rr_count", (id_log.size() >= 5) ? 5 : id_log.size(), 5);
        for (int i = 0; i < 5 && i < id_log.size(); i++) check("rr_order", id_log[i], i % NREQ);
        for (int i = 0; i < 4 && i + 1 < cyc_log.size(); i++)
            check("rr_spacing", cyc_log[i+1] - cyc_log[i], 3);

        // Wrap: grant to 3, then 0 and 3 compete.
        req_valid = '0; repeat (3) step();
        req_valid = 4'b1000; step(); req_valid = '0;
        repeat (4) step();
        id_log.delete();
        req_valid = 4'b1001; step(); req_valid = '0;
        repeat (4) step();
        check("wrap_id", (id_log.size() > 0) ? id_log[0] : -1, 0);

        // Backpressure with another requester waiting.
        set_req(1, 8'hA5, 8'h5A, 1);
        res_ready = 1'b0; req_valid = 4'b0001; step();
        req_valid = 4'b0010;
        repeat (7) step();
        res_ready = 1'b1;
        req_valid = '0; step();
        req_valid = 4'b0010; step(); req_valid = '0;
        repeat (4) step();

        // Reset while the adder is being driven.
        req_valid = 4'b0001; step(); req_valid = '0;
        rst = 1'b1; step(); rst = 1'b0;
        check("abort_res_valid", int'(res_valid), 0);
        check("abort_req_ready", int'(req_ready), 0);
        check("abort_add_X", int'(add_X), 0);
        id_log.delete();
        req_valid = 4'b0010; step(); req_valid = '0;
        repeat (4) step();
        check("abort_next_id", (id_log.size() > 0) ? id_log[0] : -1, 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain, bounded.
        req_valid = '0; res_ready = 1'b1;
        for (int n = 0; n < 20 && (sb.size() != 0 || outstanding); n++) step();
        check("drain_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
